// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the multiplexed seven-segment driver.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low segment codes, bit order g..a; element 0 is the code for hex 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed, double-buffered hex display driver for a common-anode module.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CW = clog2(REFRESH_DIV);
    localparam int IW = clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    generate
        if (DIGITS < 1 || DIGITS > 8 || REFRESH_DIV < 2) begin : g_bad_params
            $error("seg_scan_display: DIGITS must be 1..8 and REFRESH_DIV >= 2");
        end
    endgenerate

    logic [CW-1:0]          cnt_reg;
    logic [IW-1:0]          idx_reg;
    logic [4*DIGITS-1:0]    pend_val_reg;
    logic [DIGITS-1:0]      pend_dp_reg;
    logic [4*DIGITS-1:0]    live_val_reg;
    logic [DIGITS-1:0]      live_dp_reg;
    seg_t                   seg_reg;
    logic                   dp_reg;
    logic [DIGITS-1:0]      an_reg;
    logic                   frame_reg;

    logic                   tick;
    logic                   boundary;
    logic [3:0]             nib_arr [DIGITS];
    logic [DIGITS-1:0]      blank_vec;
    logic [DIGITS-1:0]      onehot;
    logic [3:0]             nib_sel;
    seg_t                   dec_seg;
    logic                   en_sel;
    seg_t                   seg_next;
    logic                   dp_next;
    logic [DIGITS-1:0]      an_next;

    assign tick     = (cnt_reg == CNT_LAST);
    assign boundary = tick && (idx_reg == IDX_LAST);

    // A digit blanks only when it and every digit to its left are zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = live_val_reg[4*gi +: 4];
            assign onehot[gi]  = (idx_reg == IW'(gi));
            if (gi == 0 || LZ_BLANK == 0) begin : g_noblank
                assign blank_vec[gi] = 1'b0;
            end else begin : g_blank
                assign blank_vec[gi] = ~|live_val_reg[4*DIGITS-1:4*gi];
            end
        end
    endgenerate

    assign nib_sel = nib_arr[idx_reg];

    hex_to_seg u_hex_to_seg (
        .hex (nib_sel),
        .seg (dec_seg)
    );

    always_comb begin
        en_sel   = digit_en[idx_reg];
        an_next  = en_sel ? ~onehot : '1;
        seg_next = (en_sel && !blank_vec[idx_reg]) ? dec_seg : SEG_BLANK;
        dp_next  = ~(en_sel & live_dp_reg[idx_reg]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            idx_reg      <= '0;
            pend_val_reg <= '0;
            pend_dp_reg  <= '0;
            live_val_reg <= '0;
            live_dp_reg  <= '0;
            seg_reg      <= SEG_BLANK;
            dp_reg       <= 1'b1;
            an_reg       <= '1;
            frame_reg    <= 1'b0;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
            if (load) begin
                pend_val_reg <= value;
                pend_dp_reg  <= dp_in;
            end
            // A load landing on the boundary bypasses pending so it is not lost for a frame.
            if (boundary) begin
                live_val_reg <= load ? value : pend_val_reg;
                live_dp_reg  <= load ? dp_in : pend_dp_reg;
            end
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            an_reg    <= an_next;
            frame_reg <= boundary;
        end
    end

    assign seg   = seg_reg;
    assign dp    = dp_reg;
    assign an    = an_reg;
    assign frame = frame_reg;

endmodule
